fifo_rr_sched: RTL and testbench

Round-robin read scheduler that shares one downstream consumer between NUM_Q fifo instances.
- Drives each fifo's read enable, which is one-hot at most.
- Drains up to BURST words from the granted queue, then rotates to the next queue.
- Presents the words on a registered valid/ready output tagged with the source queue index.
- Sits between the per-channel fifos (first-word fall-through read data, empty flag, read on empty is illegal) and the single consumer.

---
 rtl/fifo_rr_sched_pkg.sv | 4 +
 rtl/fifo_rr_sched_pick.sv | 20 ++
 rtl/fifo_rr_sched.sv | 64 ++++++
 tb/tb_fifo_rr_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_sched_pkg.sv
// fifo_rr_sched_pkg: shared scheduler state encoding.
package fifo_rr_sched_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/fifo_rr_sched_pick.sv
// rr_pick: combinational round-robin picker over a doubled request vector.
module rr_pick #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         any,
    output logic [W-1:0] grant
);
    logic [2*N-1:0] dbl;
    int k;
    always_comb begin
        dbl = {req, req};
        k = 0;
        for (int i = N - 1; i >= 0; i--) k = dbl[int'(last) + 1 + i] ? i : k;
        grant = W'((int'(last) + 1 + k) % N);
        any = |req;
    end
endmodule

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin burst reader sharing one consumer between NUM_Q fifos.
module fifo_rr_sched
    import fifo_rr_sched_pkg::*;
#(
    parameter int NUM_Q = 4,
    parameter int DATAW = 8,
    parameter int BURST = 4,
    localparam int QW = $clog2(NUM_Q),
    localparam int CW = $clog2(BURST) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_Q-1:0]   i_fifo_empty,
    input  logic [NUM_Q*DATAW-1:0] i_fifo_data,
    output logic [NUM_Q-1:0]   o_fifo_rd_en,
    output logic [DATAW-1:0]   o_data,
    output logic [QW-1:0]      o_src,
    output logic               o_valid,
    input  logic               i_ready
);
    state_t state;
    logic [QW-1:0] cur, last, pick;
    logic [CW-1:0] cnt;
    logic any, ld, pop;
    rr_pick #(.N(NUM_Q)) u_pick (
        .req(~i_fifo_empty),
        .last(last),
        .any(any),
        .grant(pick)
    );
    always_comb begin
        ld = !o_valid || i_ready;
        pop = state == GRANT && ld && !i_fifo_empty[cur];
        o_fifo_rd_en = pop ? NUM_Q'(1) << cur : '0;
    end
    // backpressure (ld=0) holds the grant; only a pop or an empty head ends it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cur <= '0;
            cnt <= '0;
            last <= QW'(NUM_Q - 1);
            o_valid <= 1'b0;
            o_data <= '0;
            o_src <= '0;
        end else begin
            if (ld) o_valid <= pop;
            if (pop) begin
                o_data <= i_fifo_data[int'(cur)*DATAW +: DATAW];
                o_src <= cur;
                cnt <= cnt + 1'b1;
            end
            if (state == IDLE && any) begin
                cur <= pick;
                cnt <= '0;
                state <= GRANT;
            end
            if (state == GRANT && ld && (i_fifo_empty[cur] || cnt == CW'(BURST - 1))) begin
                last <= cur;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rr_sched.sv
// tb_fifo_rr_sched: fifo models, cycle model of the scheduler rules, directed tests.
module tb_fifo_rr_sched;
    localparam int NQ = 4;
    localparam int DW = 8;
    localparam int BURST = 4;
    logic clk, rst, i_ready, o_valid;
    logic [NQ-1:0] fe, o_fifo_rd_en, rd_cap;
    logic [NQ*DW-1:0] fd;
    logic [DW-1:0] o_data;
    logic [1:0] o_src;
    logic [DW-1:0] mem [NQ][64];
    int hd [NQ];
    int tl [NQ];
    int checks = 0, errors = 0, cyc = 0, npop = 0, nvalid = 0, nlog = 0;
    logic [DW-1:0] log_d [128];
    int log_s [128];
    int log_c [128];
    int m_busy = 0, m_q = 0, m_n = 0, m_last = NQ - 1, m_v = 0, m_s = 0, m_ld, p, j;
    logic [DW-1:0] m_d = 0;
    int exp_v, exp_rd;

    fifo_rr_sched #(.NUM_Q(NQ), .DATAW(DW), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .i_fifo_empty(fe), .i_fifo_data(fd),
        .o_fifo_rd_en(o_fifo_rd_en), .o_data(o_data), .o_src(o_src),
        .o_valid(o_valid), .i_ready(i_ready)
    );

    for (genvar g = 0; g < NQ; g++) begin : g_fifo
        assign fe[g] = tl[g] == hd[g];
        assign fd[g*DW +: DW] = mem[g][hd[g]];
    end

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // outputs sampled mid-cycle; rd_en captured here is what the fifos see at the next edge
    always @(negedge clk) begin
        cyc++;
        exp_v = rst ? 0 : m_v;
        exp_rd = (!rst && m_busy != 0 && (m_v == 0 || i_ready) && tl[m_q] != hd[m_q]) ? (1 << m_q) : 0;
        chk("o_valid", int'(o_valid), exp_v);
        if (exp_v != 0) begin
            chk("o_data", int'(o_data), int'(m_d));
            chk("o_src", int'(o_src), m_s);
        end
        chk("rd_en", int'(o_fifo_rd_en), exp_rd);
        if ((o_fifo_rd_en & fe) != 0) chk("pop_on_empty", int'(o_fifo_rd_en & fe), 0);
        rd_cap = o_fifo_rd_en;
        npop += $countones(o_fifo_rd_en);
        if (o_valid) nvalid++;
        if (o_valid && i_ready) begin
            log_d[nlog] = o_data;
            log_s[nlog] = int'(o_src);
            log_c[nlog] = cyc;
            nlog++;
        end
    end

    // model of the scheduling rules, then the fifo pops the DUT requested
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_q = 0; m_n = 0; m_last = NQ - 1; m_v = 0; m_d = 0; m_s = 0;
        end else begin
            m_ld = (m_v == 0 || i_ready) ? 1 : 0;
            if (m_busy == 0) begin
                if (m_ld != 0) m_v = 0;
                for (int k = 1; k <= NQ; k++) begin
                    j = (m_last + k) % NQ;
                    if (m_busy == 0 && tl[j] != hd[j]) begin
                        m_q = j; m_n = 0; m_busy = 1;
                    end
                end
            end else begin
                p = (m_ld != 0 && tl[m_q] != hd[m_q]) ? 1 : 0;
                if (m_ld != 0) m_v = p;
                if (p != 0) begin
                    m_d = mem[m_q][hd[m_q]]; m_s = m_q; m_n++;
                end
                if ((p != 0 && m_n == BURST) || (m_ld != 0 && p == 0)) begin
                    m_busy = 0; m_last = m_q;
                end
            end
        end
        for (int q = 0; q < NQ; q++) if (rd_cap[q] && tl[q] != hd[q]) hd[q]++;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int q, input int v);
        mem[q][tl[q]] = DW'(v);
        tl[q]++;
    endtask

    task automatic wait_xfers(input string name, input int base, input int n, input int budget);
        int b;
        b = budget;
        while (nlog - base < n && b > 0) begin
            step(1);
            b--;
        end
        if (nlog - base < n) chk({name, "_timeout"}, nlog - base, n);
    endtask

    int base, p0, v0;
    initial begin
        for (int q = 0; q < NQ; q++) begin
            hd[q] = 0;
            tl[q] = 0;
        end
        rd_cap = 0;
        rst = 1;
        i_ready = 1;
        step(3);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_src", int'(o_src), 0);
        chk("rst_rd_en", int'(o_fifo_rd_en), 0);
        rst = 0;
        p0 = npop; v0 = nvalid;
        step(20);
        chk("idle_pops", npop - p0, 0);
        chk("idle_valid", nvalid - v0, 0);

        base = nlog; p0 = npop;
        for (int i = 0; i < 6; i++) push(2, 'h10 + i);
        wait_xfers("q2", base, 6, 40);
        step(4);
        for (int i = 0; i < 6; i++) begin
            chk("q2_data", int'(log_d[base+i]), 'h10 + i);
            chk("q2_src", log_s[base+i], 2);
            if (i > 0) chk("q2_gap", log_c[base+i] - log_c[base+i-1], i == 4 ? 2 : 1);
        end
        chk("q2_pops", npop - p0, 6);

        rst = 1;
        step(1);
        rst = 0;
        base = nlog; p0 = npop;
        for (int q = 0; q < NQ; q++) for (int i = 0; i < 8; i++) push(q, q * 16 + i);
        wait_xfers("all", base, 32, 100);
        step(4);
        for (int k = 0; k < 32; k++) begin
            chk("all_src", log_s[base+k], (k / 4) % 4);
            chk("all_data", int'(log_d[base+k]), ((k / 4) % 4) * 16 + (k / 16) * 4 + k % 4);
        end
        chk("all_pops", npop - p0, 32);

        base = nlog; p0 = npop;
        for (int i = 0; i < 3; i++) push(1, 'h40 + i);
        wait_xfers("q1", base, 3, 30);
        step(5);
        for (int i = 0; i < 3; i++) chk("q1_data", int'(log_d[base+i]), 'h40 + i);
        chk("q1_count", nlog - base, 3);
        chk("q1_pops", npop - p0, 3);

        base = nlog; p0 = npop;
        for (int i = 0; i < 10; i++) push(0, 'h50 + i);
        for (int k = 0; k < 200 && nlog - base < 10; k++) begin
            i_ready = (k % 3 == 0);
            step(1);
        end
        i_ready = 1;
        step(5);
        chk("stall_count", nlog - base, 10);
        for (int i = 0; i < 10; i++) begin
            chk("stall_data", int'(log_d[base+i]), 'h50 + i);
            chk("stall_src", log_s[base+i], 0);
        end
        chk("stall_pops", npop - p0, 10);

        base = nlog;
        for (int i = 0; i < 8; i++) push(3, 'h60 + i);
        wait_xfers("mid", base, 2, 20);
        rst = 1;
        #1;
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_data", int'(o_data), 0);
        push(0, 'h70);
        step(1);
        rst = 0;
        wait_xfers("post", base, 8, 60);
        step(5);
        begin
            int ed [8] = '{'h60, 'h61, 'h70, 'h63, 'h64, 'h65, 'h66, 'h67};
            int es [8] = '{3, 3, 0, 3, 3, 3, 3, 3};
            for (int i = 0; i < 8; i++) begin
                chk("post_data", int'(log_d[base+i]), ed[i]);
                chk("post_src", log_s[base+i], es[i]);
            end
        end
        chk("post_count", nlog - base, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
